// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write side: widths, the zero
// register, the write-source encoding and the queued result layout.
package regfile_wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Which source drives the regfile write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_LAT
    } wb_src_e;

    // One queued long-latency result: destination register and value.
    typedef struct packed {
        logic [REG_W-1:0] num;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small FIFO holding out-of-order long-latency results until the write port
// is free. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    // Advance read/write pointers; overflow of the wrap bit handles wrap-around.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Store pushed entries.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/regfile_wb.sv
// Write-side front end of the register file: arbitrates between in-order
// pipeline writeback and queued long-latency results, registers the write
// port, and tracks registers still awaiting a long-latency result.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_wb_en,
    input  logic [REG_W-1:0] pipe_wb_num,
    input  logic [XLEN-1:0]  pipe_wb_data,
    input  logic             lat_valid,
    input  logic [REG_W-1:0] lat_num,
    input  logic [XLEN-1:0]  lat_data,
    output logic             lat_ready,
    input  logic             issue_en,
    input  logic [REG_W-1:0] issue_num,
    output logic [REG_W-1:0] write_num,
    output logic [XLEN-1:0]  write_data,
    output logic             write_en,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic             pipe_stall
);

    wb_entry_t fifo_head;
    wb_entry_t fifo_in;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_src_e   src;
    logic      wb_from_lat;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;

    assign fifo_in   = '{num: lat_num, data: lat_data};
    assign fifo_push = lat_valid && !fifo_full;
    assign fifo_pop  = (src == SRC_LAT);
    assign lat_ready = !fifo_full;
    assign pipe_stall = fifo_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Pick the write-port source: pipeline first, then FIFO head, else idle.
    always_comb begin
        // NOTE: default first so every path assigns src and no latch is inferred.
        src = SRC_NONE;
        if (pipe_wb_en && pipe_wb_num != REG_ZERO)
            src = SRC_PIPE;
        else if (!fifo_empty)
            src = SRC_LAT;
    end

    // Registered write port; FIFO entries for $0 are consumed without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en    <= 1'b0;
            write_num   <= REG_ZERO;
            write_data  <= '0;
            wb_from_lat <= 1'b0;
        end else begin
            case (src)
                SRC_PIPE: begin
                    write_en    <= 1'b1;
                    write_num   <= pipe_wb_num;
                    write_data  <= pipe_wb_data;
                    wb_from_lat <= 1'b0;
                end
                SRC_LAT: begin
                    write_en    <= (fifo_head.num != REG_ZERO);
                    write_num   <= fifo_head.num;
                    write_data  <= fifo_head.data;
                    wb_from_lat <= 1'b1;
                end
                default: begin
                    write_en    <= 1'b0;
                    wb_from_lat <= 1'b0;
                end
            endcase
        end
    end

    // Pending bits set on issue and clear when the regfile commits a FIFO result.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_en && issue_num != REG_ZERO)
            busy_set = NUM_REGS'(1) << issue_num;
        if (write_en && wb_from_lat)
            busy_clr = NUM_REGS'(1) << write_num;
    end

    // Scoreboard update; a same-cycle set overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_mask <= '0;
        else
            busy_mask <= (busy_mask & ~busy_clr) | busy_set;
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: drives pipeline, long-latency and issue
// traffic and checks the write port, scoreboard and a bench-side regfile.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_num;
    logic [31:0] pipe_wb_data;
    logic        lat_valid;
    logic [4:0]  lat_num;
    logic [31:0] lat_data;
    logic        lat_ready;
    logic        issue_en;
    logic [4:0]  issue_num;
    logic [4:0]  write_num;
    logic [31:0] write_data;
    logic        write_en;
    logic [31:0] busy_mask;
    logic        pipe_stall;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rf [32];

    regfile_wb #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_num  (pipe_wb_num),
        .pipe_wb_data (pipe_wb_data),
        .lat_valid    (lat_valid),
        .lat_num      (lat_num),
        .lat_data     (lat_data),
        .lat_ready    (lat_ready),
        .issue_en     (issue_en),
        .issue_num    (issue_num),
        .write_num    (write_num),
        .write_data   (write_data),
        .write_en     (write_en),
        .busy_mask    (busy_mask),
        .pipe_stall   (pipe_stall)
    );

    always #5 clk = ~clk;

    // Bench-side register file: commits the write port at each posedge.
    always @(posedge clk) begin
        if (write_en && write_num != 5'd0)
            rf[write_num] <= write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wb_en = 1'b0; pipe_wb_num = 5'd0; pipe_wb_data = 32'd0;
        lat_valid  = 1'b0; lat_num     = 5'd0; lat_data     = 32'd0;
        issue_en   = 1'b0; issue_num   = 5'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] n, input logic [31:0] d);
        pipe_wb_en = 1'b1; pipe_wb_num = n; pipe_wb_data = d;
    endtask

    task automatic drive_lat(input logic [4:0] n, input logic [31:0] d);
        lat_valid = 1'b1; lat_num = n; lat_data = d;
    endtask

    task automatic exp_port(input string tag, input logic en, input logic [4:0] n, input logic [31:0] d);
        n_vec++;
        if (write_en !== en) begin
            n_err++; $display("FAIL %s write_en: got %b want %b", tag, write_en, en);
        end
        if (en) begin
            n_vec++;
            if (write_num !== n || write_data !== d) begin
                n_err++;
                $display("FAIL %s port: got $%0d=%h want $%0d=%h", tag, write_num, write_data, n, d);
            end
        end
    endtask

    task automatic exp_rf(input string tag, input logic [4:0] n, input logic [31:0] d);
        n_vec++;
        if (rf[n] !== d) begin
            n_err++; $display("FAIL %s rf[%0d]: got %h want %h", tag, n, rf[n], d);
        end
    endtask

    task automatic exp_flow(input string tag, input logic rdy, input logic stall);
        n_vec++;
        if (lat_ready !== rdy || pipe_stall !== stall) begin
            n_err++;
            $display("FAIL %s flow: got ready=%b stall=%b want ready=%b stall=%b", tag, lat_ready, pipe_stall, rdy, stall);
        end
    endtask

    task automatic exp_busy(input string tag, input logic [31:0] m);
        n_vec++;
        if (busy_mask !== m) begin
            n_err++; $display("FAIL %s busy_mask: got %h want %h", tag, busy_mask, m);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if (write_en !== 1'b0 || write_num !== 5'd0 || write_data !== 32'd0) begin
            n_err++; $display("FAIL reset port: got en=%b $%0d=%h want all zero", write_en, write_num, write_data);
        end
        exp_busy("reset", 32'h0);
        exp_flow("reset", 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        exp_port("reset_idle", 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_pipe_write();
        drive_pipe(5'd5, 32'hDEADBEEF);
        tick();
        idle_inputs();
        exp_port("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        exp_port("pipe_after", 1'b0, 5'd0, 32'd0);
        exp_rf("pipe", 5'd5, 32'hDEADBEEF);
    endtask

    task automatic test_lat_write();
        issue_en = 1'b1; issue_num = 5'd8;
        tick();
        idle_inputs();
        exp_busy("issue", 32'h0000_0100);
        tick(); tick();
        drive_lat(5'd8, 32'h12345678);
        tick();
        idle_inputs();
        exp_port("lat_no_bypass", 1'b0, 5'd0, 32'd0);
        tick();
        exp_port("lat", 1'b1, 5'd8, 32'h12345678);
        exp_busy("lat_pending", 32'h0000_0100);
        tick();
        exp_busy("lat_commit", 32'h0);
        exp_rf("lat", 5'd8, 32'h12345678);
        exp_port("lat_after", 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_simultaneous();
        drive_pipe(5'd3, 32'h1);
        drive_lat(5'd4, 32'h2);
        tick();
        idle_inputs();
        exp_port("simul_first", 1'b1, 5'd3, 32'h1);
        tick();
        exp_port("simul_second", 1'b1, 5'd4, 32'h2);
        tick();
        exp_port("simul_done", 1'b0, 5'd0, 32'd0);
        exp_rf("simul", 5'd3, 32'h1);
        exp_rf("simul", 5'd4, 32'h2);
    endtask

    task automatic test_back_to_back();
        drive_pipe(5'd10, 32'hA0A0_0010);
        drive_lat(5'd20, 32'hAAAA_0020);
        tick();
        exp_port("b2b_p10", 1'b1, 5'd10, 32'hA0A0_0010);
        exp_flow("b2b_one", 1'b1, 1'b0);
        drive_pipe(5'd11, 32'hA0A0_0011);
        drive_lat(5'd21, 32'hBBBB_0021);
        tick();
        exp_port("b2b_p11", 1'b1, 5'd11, 32'hA0A0_0011);
        exp_flow("b2b_full", 1'b0, 1'b1);
        // Bubble while full; the third result is offered but must wait.
        pipe_wb_en = 1'b0;
        drive_lat(5'd22, 32'hCCCC_0022);
        tick();
        exp_port("b2b_l20", 1'b1, 5'd20, 32'hAAAA_0020);
        exp_flow("b2b_drain", 1'b1, 1'b0);
        drive_pipe(5'd12, 32'hA0A0_0012);
        tick();
        exp_port("b2b_p12", 1'b1, 5'd12, 32'hA0A0_0012);
        exp_flow("b2b_refull", 1'b0, 1'b1);
        idle_inputs();
        tick();
        exp_port("b2b_l21", 1'b1, 5'd21, 32'hBBBB_0021);
        tick();
        exp_port("b2b_l22", 1'b1, 5'd22, 32'hCCCC_0022);
        tick();
        exp_port("b2b_idle", 1'b0, 5'd0, 32'd0);
        exp_flow("b2b_empty", 1'b1, 1'b0);
        exp_rf("b2b", 5'd10, 32'hA0A0_0010);
        exp_rf("b2b", 5'd11, 32'hA0A0_0011);
        exp_rf("b2b", 5'd12, 32'hA0A0_0012);
        exp_rf("b2b", 5'd20, 32'hAAAA_0020);
        exp_rf("b2b", 5'd21, 32'hBBBB_0021);
        exp_rf("b2b", 5'd22, 32'hCCCC_0022);
    endtask

    task automatic test_zero_reg();
        drive_pipe(5'd0, 32'hFFFF_FFFF);
        drive_lat(5'd0, 32'hAAAA_AAAA);
        issue_en = 1'b1; issue_num = 5'd0;
        tick();
        idle_inputs();
        exp_port("zero_pipe", 1'b0, 5'd0, 32'd0);
        exp_busy("zero_issue", 32'h0);
        tick();
        exp_port("zero_lat", 1'b0, 5'd0, 32'd0);
        tick();
        exp_port("zero_idle", 1'b0, 5'd0, 32'd0);
        exp_rf("zero", 5'd0, 32'h0);
    endtask

    task automatic test_reset_mid();
        issue_en = 1'b1; issue_num = 5'd8;
        tick();
        issue_num = 5'd9;
        tick();
        idle_inputs();
        drive_pipe(5'd1, 32'h1111_1111);
        drive_lat(5'd8, 32'h8888_8888);
        tick();
        drive_pipe(5'd2, 32'h2222_2222);
        drive_lat(5'd9, 32'h9999_9999);
        tick();
        idle_inputs();
        exp_busy("rstmid_before", 32'h0000_0300);
        exp_flow("rstmid_before", 1'b0, 1'b1);
        exp_port("rstmid_before", 1'b1, 5'd2, 32'h2222_2222);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (write_en !== 1'b0 || write_num !== 5'd0 || write_data !== 32'd0) begin
            n_err++; $display("FAIL rstmid async port: got en=%b $%0d=%h want all zero", write_en, write_num, write_data);
        end
        exp_busy("rstmid_async", 32'h0);
        exp_flow("rstmid_async", 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_port("rstmid_after", 1'b0, 5'd0, 32'd0);
        end
        exp_busy("rstmid_after", 32'h0);
        exp_flow("rstmid_after", 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf[i] = 32'd0;
        test_reset();
        test_pipe_write();
        test_lat_write();
        test_simultaneous();
        test_back_to_back();
        test_zero_reg();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
